// File: rtl/capi_put_pkg.sv
// Shared PSL command/response codes, tag widths and the registered command record.
// Pure definitions: no latency, no flow control.
package capi_put_pkg;

  localparam int TAG_PFX_W = 3;
  localparam int PUT_TAG_W = 5;

  localparam logic [12:0] CAPI_WRITE_NA = 13'h0D00;
  localparam logic [12:0] CAPI_WRITE_MI = 13'h0D60;

  localparam logic [7:0] RSP_DONE      = 8'h00;
  localparam logic [7:0] RSP_LOCAL_REJ = 8'hFF;

  typedef logic [PUT_TAG_W-1:0] put_tag_t;

  typedef struct packed {
    logic [7:0]  ctag;
    logic        ctagpar;
    logic [12:0] com;
    logic        compar;
    logic [2:0]  cabt;
    logic [11:0] csize;
    logic [15:0] cch;
  } ah_cmd_t;

  // Odd parity: zero-extension does not change the result, so one width serves all fields.
  function automatic logic odd_par(input logic [15:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/capi_put_tag_track.sv
// Per-tag outstanding bitmap with running count and idle indication.
// Latency: set/clear visible the cycle after the request; no backpressure.
module capi_put_tag_track
  import capi_put_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       set_v,
  input  put_tag_t   set_tag,
  input  logic       clr_v,
  input  put_tag_t   clr_tag,
  input  put_tag_t   pop_tag,
  output logic       pop_busy,
  input  put_tag_t   rsp_tag,
  output logic       rsp_busy,
  input  logic       cmd_vld_q,
  output logic [5:0] outst_cnt,
  output logic       idle
);

  logic [31:0] outst_q;
  logic [5:0]  cnt_q;

  assign pop_busy = outst_q[pop_tag];
  assign rsp_busy = outst_q[rsp_tag];

  // A set and a clear never target the same tag: set needs the bit low, clear needs it high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outst_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (set_v) outst_q[set_tag] <= 1'b1;
      if (clr_v) outst_q[clr_tag] <= 1'b0;
      if (set_v && !clr_v)      cnt_q <= cnt_q + 6'd1;
      else if (clr_v && !set_v) cnt_q <= cnt_q - 6'd1;
    end
  end

  assign outst_cnt = cnt_q;
  assign idle      = (cnt_q == 6'd0) && !cmd_vld_q;

endmodule

// File: rtl/capi_put_cmd_issue.sv
// Pops put descriptors and issues PSL write commands; retires ha_r* responses as per-tag done pulses.
// Latency: ah_cvalid 1 cycle after pop, done 1 cycle after response; pop stalls on zero credit or busy tag.
module capi_put_cmd_issue
  import capi_put_pkg::*;
#(
  parameter int         ea_width    = 65,
  parameter int         sid_width   = 2,
  parameter logic [2:0] tag_prefix  = 3'b101,
  parameter int         max_credits = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_cmd_v,
  output logic                 o_cmd_r,
  input  logic [4:0]           i_cmd_tag,
  input  logic [9:0]           i_cmd_tsize,
  input  logic [ea_width-1:0]  i_cmd_ea,
  input  logic [sid_width-1:0] i_cmd_sid,
  input  logic                 i_cmd_f,
  input  logic [10:0]          i_cmd_aux,
  input  logic [9:0]           i_cmd_ctxt,
  input  logic                 i_croom_we,
  input  logic [7:0]           i_croom,
  output logic                 o_ah_cvalid,
  output logic [7:0]           o_ah_ctag,
  output logic                 o_ah_ctagpar,
  output logic [12:0]          o_ah_com,
  output logic                 o_ah_compar,
  output logic [2:0]           o_ah_cabt,
  output logic [ea_width-1:0]  o_ah_cea,
  output logic [11:0]          o_ah_csize,
  output logic [15:0]          o_ah_cch,
  input  logic                 i_ha_rvalid,
  input  logic [7:0]           i_ha_rtag,
  input  logic [7:0]           i_ha_response,
  input  logic [8:0]           i_ha_rcredits,
  output logic                 o_done_v,
  output logic [4:0]           o_done_tag,
  output logic                 o_done_sts,
  output logic [7:0]           o_done_resp,
  output logic                 o_unexp_rsp,
  output logic [5:0]           o_outst_cnt,
  output logic                 o_idle
);

  localparam logic [11:0] CRED_MAX = 12'(max_credits);

  logic [8:0]          credits_q, credits_d;
  logic [11:0]         cred_sum;
  logic                zero_size, tag_busy, rsp_busy, rsp_hit, issue;
  logic [7:0]          ctag_d;
  logic [12:0]         com_d;
  ah_cmd_t             cmd_q;
  logic [ea_width-1:0] cea_q;
  logic                cvalid_q;
  logic                done_v_q, done_sts_q, unexp_q;
  logic [4:0]          done_tag_q;
  logic [7:0]          done_resp_q;
  logic                unused_fields;

  assign unused_fields = ^{i_cmd_sid, i_cmd_aux[7:0]};

  // Zero-size rejects share the done port with responses, so they yield to ha_rvalid.
  assign zero_size = (i_cmd_tsize == 10'd0);
  assign o_cmd_r   = i_cmd_v & ~tag_busy & (zero_size ? ~i_ha_rvalid : (credits_q != 9'd0));
  assign issue     = o_cmd_r & ~zero_size;
  assign rsp_hit   = i_ha_rvalid & (i_ha_rtag[7:5] == tag_prefix) & rsp_busy;

  always_comb begin
    cred_sum = {3'b000, credits_q} - {11'd0, issue}
             + (i_ha_rvalid ? {{3{i_ha_rcredits[8]}}, i_ha_rcredits} : 12'd0);
    if (cred_sum[11])             credits_d = '0;
    else if (cred_sum > CRED_MAX) credits_d = CRED_MAX[8:0];
    else                          credits_d = cred_sum[8:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        credits_q <= '0;
    else if (i_croom_we) credits_q <= {1'b0, i_croom};
    else                 credits_q <= credits_d;
  end

  assign ctag_d = {tag_prefix, i_cmd_tag};
  assign com_d  = i_cmd_f ? CAPI_WRITE_MI : CAPI_WRITE_NA;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cvalid_q <= 1'b0;
      cmd_q    <= '0;
      cea_q    <= '0;
    end else begin
      cvalid_q <= issue;
      if (issue) begin
        cmd_q <= '{ctag: ctag_d, ctagpar: odd_par({8'h00, ctag_d}),
                   com: com_d, compar: odd_par({3'b000, com_d}),
                   cabt: i_cmd_aux[10:8], csize: {2'b00, i_cmd_tsize},
                   cch: {6'b000000, i_cmd_ctxt}};
        cea_q <= i_cmd_ea;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_v_q    <= 1'b0;
      done_tag_q  <= '0;
      done_sts_q  <= 1'b0;
      done_resp_q <= '0;
      unexp_q     <= 1'b0;
    end else begin
      done_v_q <= rsp_hit | (o_cmd_r & zero_size);
      unexp_q  <= unexp_q | (i_ha_rvalid & ~rsp_hit);
      if (rsp_hit) begin
        done_tag_q  <= i_ha_rtag[4:0];
        done_resp_q <= i_ha_response;
        done_sts_q  <= (i_ha_response != RSP_DONE);
      end else if (o_cmd_r && zero_size) begin
        done_tag_q  <= i_cmd_tag;
        done_resp_q <= RSP_LOCAL_REJ;
        done_sts_q  <= 1'b1;
      end
    end
  end

  capi_put_tag_track u_tag_track (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_v     (issue),
    .set_tag   (i_cmd_tag),
    .clr_v     (rsp_hit),
    .clr_tag   (i_ha_rtag[4:0]),
    .pop_tag   (i_cmd_tag),
    .pop_busy  (tag_busy),
    .rsp_tag   (i_ha_rtag[4:0]),
    .rsp_busy  (rsp_busy),
    .cmd_vld_q (cvalid_q),
    .outst_cnt (o_outst_cnt),
    .idle      (o_idle)
  );

  assign o_ah_cvalid  = cvalid_q;
  assign o_ah_ctag    = cmd_q.ctag;
  assign o_ah_ctagpar = cmd_q.ctagpar;
  assign o_ah_com     = cmd_q.com;
  assign o_ah_compar  = cmd_q.compar;
  assign o_ah_cabt    = cmd_q.cabt;
  assign o_ah_cea     = cea_q;
  assign o_ah_csize   = cmd_q.csize;
  assign o_ah_cch     = cmd_q.cch;
  assign o_done_v     = done_v_q;
  assign o_done_tag   = done_tag_q;
  assign o_done_sts   = done_sts_q;
  assign o_done_resp  = done_resp_q;
  assign o_unexp_rsp  = unexp_q;

endmodule
